// File: rtl/bht_predictor_if.sv
// bht_predictor_if
//   Lookup and resolve bundle between the pipeline and the branch history
//   table.
//   master : the pipeline. It drives the lookup PC and the resolve strobe,
//            PC, captured history and outcome.
//   slave  : the predictor. It returns the prediction, the raw counter and
//            the history used for the lookup.
//   Signals:
//     lookup_pc_i    PC of the branch in ID
//     predict_o      1 = predict taken
//     counter_o      raw counter at the lookup index
//     hist_o         global history used for this lookup
//     update_i       one-cycle strobe: a branch resolved
//     update_pc_i    PC of the resolved branch
//     update_hist_i  hist_o captured at lookup time
//     result_i       actual outcome, 1 = taken
interface bht_predictor_if #(
  parameter int CNT_W  = 2,
  parameter int HIST_W = 4
);
  logic [31:0]       lookup_pc_i;
  logic              predict_o;
  logic [CNT_W-1:0]  counter_o;
  logic [HIST_W-1:0] hist_o;
  logic              update_i;
  logic [31:0]       update_pc_i;
  logic [HIST_W-1:0] update_hist_i;
  logic              result_i;

  modport master (
    output lookup_pc_i, update_i, update_pc_i, update_hist_i, result_i,
    input  predict_o, counter_o, hist_o
  );

  modport slave (
    input  lookup_pc_i, update_i, update_pc_i, update_hist_i, result_i,
    output predict_o, counter_o, hist_o
  );
endinterface

// File: rtl/bht_predictor.sv
// bht_predictor
//   Branch history table of ENTRIES saturating counters (CNT_W bits each),
//   indexed by pc[IDX_W+1:2]. Lookup is combinational. The addressed
//   counter is trained one step toward the outcome on each resolve strobe.
//   Optional gshare mode (macro BHT_GSHARE_EN) XORs a global history
//   register into both the lookup index and the update index.
//   Ports:
//     clk_i  clock, rising edge
//     rst_i  synchronous active-high reset. It loads RESET_VAL into every
//            counter and clears the history.
//     bus    bht_predictor_if.slave (lookup / update bundle)
module bht_predictor #(
  parameter int               ENTRIES   = 64,
  parameter int               CNT_W     = 2,
  parameter logic [CNT_W-1:0] RESET_VAL = '1,
  parameter int               HIST_W    = 4
) (
  input logic           clk_i,
  input logic           rst_i,
  bht_predictor_if.slave bus
);
  localparam int               IDX_W   = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // One saturating step: up toward CNT_MAX or down toward zero, never wraps.
  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] cnt,
                                                 input logic            up);
    logic [CNT_W-1:0] res;
    res = cnt;
    if (up) begin
      if (cnt != CNT_MAX) res = cnt + CNT_W'(1);
    end else begin
      if (cnt != '0) res = cnt - CNT_W'(1);
    end
    return res;
  endfunction

  logic [CNT_W-1:0] table_q [ENTRIES];
  logic [IDX_W-1:0] lpc_idx;
  logic [IDX_W-1:0] upc_idx;
  logic [IDX_W-1:0] lidx;
  logic [IDX_W-1:0] uidx;

  // Word-aligned base index. Bits 1:0 and the bits above the index alias.
  assign lpc_idx = bus.lookup_pc_i[IDX_W+1:2];
  assign upc_idx = bus.update_pc_i[IDX_W+1:2];

`ifdef BHT_GSHARE_EN
  logic [HIST_W-1:0] ghr;

  // Shift in each accepted outcome. A plain shift also covers HIST_W = 1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ghr <= '0;
    end else if (bus.update_i) begin
      ghr <= (ghr << 1) | HIST_W'(bus.result_i);
    end
  end

  assign bus.hist_o = ghr;
  // HIST_W <= IDX_W, so the history is zero-extended into the index.
  assign lidx = lpc_idx ^ IDX_W'(ghr);
  // Train with the history captured at lookup time, not the current GHR.
  assign uidx = upc_idx ^ IDX_W'(bus.update_hist_i);

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.lookup_pc_i[31:IDX_W+2], bus.lookup_pc_i[1:0],
                              bus.update_pc_i[31:IDX_W+2], bus.update_pc_i[1:0]};
`else
  assign bus.hist_o = '0;
  assign lidx       = lpc_idx;
  assign uidx       = upc_idx;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.lookup_pc_i[31:IDX_W+2], bus.lookup_pc_i[1:0],
                              bus.update_pc_i[31:IDX_W+2], bus.update_pc_i[1:0],
                              bus.update_hist_i};
`endif

  // Reset overrides a simultaneous update. At most one entry changes per cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= RESET_VAL;
    end else if (bus.update_i) begin
      table_q[uidx] <= sat_step(table_q[uidx], bus.result_i);
    end
  end

  // No write-to-read bypass: a same-cycle lookup sees the pre-update value.
  assign bus.counter_o = table_q[lidx];
  assign bus.predict_o = bus.counter_o[CNT_W-1];
endmodule
